// File: rtl/seg7_pkg.sv
// ============================================================================
// Module      : seg7_pkg
// Description : Active-low 7-segment glyph patterns and shared helpers for
//               the scan decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    typedef logic [6:0] seg7_pat_t;

    localparam seg7_pat_t SEG_0     = 7'h40;
    localparam seg7_pat_t SEG_1     = 7'h79;
    localparam seg7_pat_t SEG_2     = 7'h24;
    localparam seg7_pat_t SEG_3     = 7'h30;
    localparam seg7_pat_t SEG_4     = 7'h19;
    localparam seg7_pat_t SEG_5     = 7'h12;
    localparam seg7_pat_t SEG_6     = 7'h02;
    localparam seg7_pat_t SEG_7     = 7'h78;
    localparam seg7_pat_t SEG_8     = 7'h00;
    localparam seg7_pat_t SEG_9     = 7'h10;
    localparam seg7_pat_t SEG_A     = 7'h08;
    localparam seg7_pat_t SEG_B     = 7'h03;
    localparam seg7_pat_t SEG_C     = 7'h46;
    localparam seg7_pat_t SEG_D     = 7'h21;
    localparam seg7_pat_t SEG_E     = 7'h06;
    localparam seg7_pat_t SEG_F     = 7'h0E;
    localparam seg7_pat_t SEG_BLANK = 7'h7F;

    // Digit-index width; a single-digit display still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan_decoder_if.sv
// ============================================================================
// Module      : seg7_scan_decoder_if
// Description : Display-bus and readback bundle between the display path
//               (master) and the scan decoder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg7_scan_decoder_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    localparam int c_idx_w = idx_width(NUM_DIGITS);

    logic [7:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    err_clr;
    logic [4*NUM_DIGITS-1:0] digits_o;
    logic [NUM_DIGITS-1:0]   valid_o;
    logic [NUM_DIGITS-1:0]   dp_o;
    logic                    upd_o;
    logic [c_idx_w-1:0]      upd_idx_o;
    logic                    err_o;

    modport master (
        output seg_n, an_n, err_clr,
        input  digits_o, valid_o, dp_o, upd_o, upd_idx_o, err_o
    );

    modport slave (
        input  seg_n, an_n, err_clr,
        output digits_o, valid_o, dp_o, upd_o, upd_idx_o, err_o
    );

endinterface

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
// ============================================================================
// Module      : seg7_pattern_decode
// Description : Combinational inverse of the hex-to-segment encoder; flags
//               legal glyphs and the blank pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  seg7_pat_t  i_pat,
    output logic       o_legal,
    output logic       o_blank,
    output logic [3:0] o_hex
);

    always_comb begin
        o_legal = 1'b1;
        o_blank = 1'b0;
        o_hex   = 4'h0;
        case (i_pat)
            SEG_0:     o_hex = 4'h0;
            SEG_1:     o_hex = 4'h1;
            SEG_2:     o_hex = 4'h2;
            SEG_3:     o_hex = 4'h3;
            SEG_4:     o_hex = 4'h4;
            SEG_5:     o_hex = 4'h5;
            SEG_6:     o_hex = 4'h6;
            SEG_7:     o_hex = 4'h7;
            SEG_8:     o_hex = 4'h8;
            SEG_9:     o_hex = 4'h9;
            SEG_A:     o_hex = 4'hA;
            SEG_B:     o_hex = 4'hB;
            SEG_C:     o_hex = 4'hC;
            SEG_D:     o_hex = 4'hD;
            SEG_E:     o_hex = 4'hE;
            SEG_F:     o_hex = 4'hF;
            SEG_BLANK: begin
                o_legal = 1'b0;
                o_blank = 1'b1;
            end
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
// ============================================================================
// Module      : seg7_scan_decoder
// Description : Reconstructs per-digit hex values from the multiplexed
//               active-low segment/anode bus. Define SEG7_DP_CAPTURE_EN to
//               include the decimal point in matching and capture it on dp_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_decoder_if.slave bus
);

    localparam int         c_idx_w  = idx_width(NUM_DIGITS);
    localparam logic [7:0] c_stable = 8'(STABLE_CYCLES);
`ifdef SEG7_DP_CAPTURE_EN
    localparam int         c_pat_w  = 8;
`else
    localparam int         c_pat_w  = 7;
`endif

    logic [c_pat_w-1:0]      r_pat;
    logic [c_pat_w-1:0]      r_prev_pat;
    logic [NUM_DIGITS-1:0]   r_an_n;
    logic [c_idx_w-1:0]      r_prev_idx;
    logic [7:0]              r_cnt;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic                    r_upd;
    logic [c_idx_w-1:0]      r_upd_idx;
    logic                    r_err;
`ifdef SEG7_DP_CAPTURE_EN
    logic [NUM_DIGITS-1:0]   r_dp;
`endif

    logic               w_any;
    logic               w_multi;
    logic [c_idx_w-1:0] w_idx;
    logic               w_tracked;
    logic               w_match;
    logic [7:0]         w_cnt_nxt;
    logic               w_commit;
    logic               w_legal;
    logic               w_blank;
    logic [3:0]         w_hex;
    logic [3:0]         w_old_digit;
    logic [3:0]         w_new_digit;
    logic               w_changed;
    logic               w_err_event;

    // Anodes reset to "none selected" so the first post-reset sample is idle
    // rather than an all-digit collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat  <= '0;
            r_an_n <= '1;
        end else begin
            r_pat  <= bus.seg_n[c_pat_w-1:0];
            r_an_n <= bus.an_n;
        end
    end

    always_comb begin
        w_any   = 1'b0;
        w_multi = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_an_n[i]) begin
                if (w_any) w_multi = 1'b1;
                w_any = 1'b1;
                w_idx = c_idx_w'(i);
            end
        end
    end

    assign w_tracked = w_any && !w_multi;

    always_comb begin
        w_match   = (r_pat == r_prev_pat) && (w_idx == r_prev_idx);
        w_cnt_nxt = 8'd1;
        if (!w_tracked) begin
            w_cnt_nxt = '0;
        end else if (w_match) begin
            w_cnt_nxt = (r_cnt == c_stable) ? c_stable : r_cnt + 8'd1;
        end
    end

    // Only the transition into saturation commits; holding there does not.
    assign w_commit = w_tracked && (w_cnt_nxt == c_stable) && (r_cnt != c_stable);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_prev_pat <= '0;
            r_prev_idx <= '0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_prev_pat <= r_pat;
            r_prev_idx <= w_idx;
        end
    end

    seg7_pattern_decode u_decode (
        .i_pat   (r_pat[6:0]),
        .o_legal (w_legal),
        .o_blank (w_blank),
        .o_hex   (w_hex)
    );

    always_comb begin
        w_old_digit = r_digits[4*w_idx +: 4];
        w_new_digit = w_legal ? w_hex : w_old_digit;
        w_changed   = (w_new_digit != w_old_digit) || (w_legal != r_valid[w_idx]);
`ifdef SEG7_DP_CAPTURE_EN
        w_changed   = w_changed || (r_dp[w_idx] == r_pat[7]);
`endif
    end

    assign w_err_event = w_multi || (w_commit && !w_legal && !w_blank);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits  <= '0;
            r_valid   <= '0;
            r_upd     <= 1'b0;
            r_upd_idx <= '0;
            r_err     <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
            r_dp      <= '0;
`endif
        end else begin
            r_upd <= w_commit && w_changed;
            if (w_commit) begin
                r_digits[4*w_idx +: 4] <= w_new_digit;
                r_valid[w_idx]         <= w_legal;
`ifdef SEG7_DP_CAPTURE_EN
                r_dp[w_idx]            <= ~r_pat[7];
`endif
                if (w_changed) r_upd_idx <= w_idx;
            end
            if (w_err_event) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.digits_o  = r_digits;
    assign bus.valid_o   = r_valid;
    assign bus.upd_o     = r_upd;
    assign bus.upd_idx_o = r_upd_idx;
    assign bus.err_o     = r_err;
`ifdef SEG7_DP_CAPTURE_EN
    assign bus.dp_o      = r_dp;
`else
    assign bus.dp_o      = '0;
`endif

endmodule

`default_nettype wire
